// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver constants, FSM state type and parity helper
package ps2_pkg;
    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;
    localparam int MAX_DATA_BITS = 9;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
    // Parity bit the wire must carry for data d under the given mode
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] d, input logic [1:0] mode);
        return (mode == PARITY_ODD) ? ~^d : ^d;
    endfunction
endpackage

// File: rtl/ps2_frame_rx_if.sv
// ps2_frame_rx_if: valid/ready receive stream with FIFO fill level
interface ps2_frame_rx_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_BITS-1:0]              rx_data;
    logic                              rx_valid;
    logic                              rx_ready;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;
    modport master (output rx_data, rx_valid, fifo_count, input rx_ready);
    modport slave  (input rx_data, rx_valid, fifo_count, output rx_ready);
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: first-word-fall-through FIFO with count and overflow pulse
module ps2_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [CW-1:0]    o_count,
    output logic             o_overflow
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             w_full, w_pop, w_wr;
    assign w_full     = r_count == CW'(DEPTH);
    assign w_pop      = i_pop & o_valid;
    assign w_wr       = i_push & (~w_full | w_pop);
    assign o_valid    = r_count != '0;
    assign o_data     = o_valid ? r_mem[r_rd] : '0;
    assign o_count    = r_count;
    assign o_overflow = r_ovf;
    // Storage write; contents need no reset since the head is gated by o_valid
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= i_data;
    end
    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_wr    <= r_wr + AW'(w_wr);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
            r_ovf   <= i_push & w_full & ~w_pop;
        end
    end
endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: oversampled PS/2 frame receiver with watchdog, error pulses and receive FIFO
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_ps2_clk,
    input  logic           i_ps2_dat,
    ps2_frame_rx_if.master rx,
    output logic           o_parity_err,
    output logic           o_frame_err,
    output logic           o_timeout_err,
    output logic           o_overflow
);
    localparam int         IDX_W = $clog2(DATA_BITS);
    localparam int         WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [1:0] MODE  = 2'(PARITY_MODE);
    logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
    logic                   r_clk_prev;
    rx_state_t              r_state, w_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [IDX_W-1:0]       r_idx;
    logic [WD_W-1:0]        r_wd;
    logic                   r_perr, r_ferr, r_terr;
    logic                   w_clk, w_dat, w_fe, w_last, w_par_ok, w_timeout;
    logic                   w_push, w_perr, w_ferr, w_store;
    assign w_clk     = r_clk_sync[SYNC_STAGES-1];
    assign w_dat     = r_dat_sync[SYNC_STAGES-1];
    assign w_fe      = r_clk_prev & ~w_clk;
    assign w_last    = r_idx == IDX_W'(DATA_BITS-1);
    assign w_par_ok  = w_dat == parity_bit(MAX_DATA_BITS'(r_shift), MODE);
    assign w_timeout = (r_state != IDLE) && !w_fe && (r_wd == WD_W'(TIMEOUT_CYCLES-1));
    // Synchronisers and edge-detect flop rest at the idle line level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
            r_clk_prev <= w_clk;
        end
    end
    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    // FSM next state: one transition per device-clock falling edge, watchdog forces IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_fe && !w_dat) ? DATA : IDLE;
            DATA:    w_next = (w_fe && w_last) ? ((MODE == PARITY_NONE) ? STOP : PARITY) : DATA;
            PARITY:  w_next = !w_fe ? PARITY : w_par_ok ? STOP : IDLE;
            STOP:    w_next = w_fe ? IDLE : STOP;
            default: w_next = IDLE;
        endcase
        if (w_timeout) w_next = IDLE;
    end
    // FSM outputs: bit capture, frame push and error decisions in the edge cycle
    always_comb begin
        w_store = (r_state == DATA) && w_fe;
        w_push  = (r_state == STOP) && w_fe && w_dat;
        w_ferr  = (r_state == STOP) && w_fe && !w_dat;
        w_perr  = (r_state == PARITY) && w_fe && !w_par_ok;
    end
    // Shift register, bit index, watchdog (cycles since last edge) and registered error pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_wd    <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_terr  <= 1'b0;
        end else begin
            if (w_store) r_shift[r_idx] <= w_dat;
            r_idx  <= (r_state == DATA) ? r_idx + IDX_W'(w_fe) : '0;
            r_wd   <= w_fe ? WD_W'(1) : (r_state == IDLE || w_timeout) ? '0 : r_wd + 1'b1;
            r_perr <= w_perr;
            r_ferr <= w_ferr;
            r_terr <= w_timeout;
        end
    end
    assign o_parity_err  = r_perr;
    assign o_frame_err   = r_ferr;
    assign o_timeout_err = r_terr;
    ps2_rx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_data     (r_shift),
        .i_pop      (rx.rx_ready),
        .o_data     (rx.rx_data),
        .o_valid    (rx.rx_valid),
        .o_count    (rx.fifo_count),
        .o_overflow (o_overflow)
    );
endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: three receiver configurations checked against a frame-level model
module tb_ps2_frame_rx;
    localparam int SYNC = 2;
    localparam int TO   = 100;
    localparam int DEP  = 4;
    typedef struct {int p; bit b;} fe_t;
    typedef struct {int c; int v;} lit_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pc[3], pd[3], rdy[3];
    logic [8:0] od[3];
    logic ov[3], pe[3], fr[3], te[3], of[3];
    logic [2:0] oc[3];
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    bit done = 0;
    int drv_p[3];
    fe_t feq[3][$];
    logic [8:0] litpop[3][$];
    int littmo[3][$];
    lit_t litcnt[3][$];
    int tot_pe[3], tot_fe[3], tot_te[3], tot_of[3];
    ps2_frame_rx_if #(.DATA_BITS(8), .FIFO_DEPTH(DEP)) if0();
    ps2_frame_rx_if #(.DATA_BITS(7), .FIFO_DEPTH(DEP)) if1();
    ps2_frame_rx_if #(.DATA_BITS(9), .FIFO_DEPTH(DEP)) if2();
    ps2_frame_rx #(.DATA_BITS(8), .PARITY_MODE(1), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEP)) dut0 (
        .clk(clk), .reset(reset), .i_ps2_clk(pc[0]), .i_ps2_dat(pd[0]), .rx(if0),
        .o_parity_err(pe[0]), .o_frame_err(fr[0]), .o_timeout_err(te[0]), .o_overflow(of[0]));
    ps2_frame_rx #(.DATA_BITS(7), .PARITY_MODE(0), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEP)) dut1 (
        .clk(clk), .reset(reset), .i_ps2_clk(pc[1]), .i_ps2_dat(pd[1]), .rx(if1),
        .o_parity_err(pe[1]), .o_frame_err(fr[1]), .o_timeout_err(te[1]), .o_overflow(of[1]));
    ps2_frame_rx #(.DATA_BITS(9), .PARITY_MODE(2), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEP)) dut2 (
        .clk(clk), .reset(reset), .i_ps2_clk(pc[2]), .i_ps2_dat(pd[2]), .rx(if2),
        .o_parity_err(pe[2]), .o_frame_err(fr[2]), .o_timeout_err(te[2]), .o_overflow(of[2]));
    assign if0.rx_ready = rdy[0];
    assign if1.rx_ready = rdy[1];
    assign if2.rx_ready = rdy[2];
    assign od[0] = {1'b0, if0.rx_data};
    assign od[1] = {2'b0, if1.rx_data};
    assign od[2] = if2.rx_data;
    assign ov[0] = if0.rx_valid;
    assign ov[1] = if1.rx_valid;
    assign ov[2] = if2.rx_valid;
    assign oc[0] = if0.fifo_count;
    assign oc[1] = if1.fifo_count;
    assign oc[2] = if2.fifo_count;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    function automatic int dbits(input int u);
        return (u == 0) ? 8 : (u == 1) ? 7 : 9;
    endfunction
    function automatic int pmode(input int u);
        return (u == 0) ? 1 : (u == 1) ? 0 : 2;
    endfunction
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic bitout(input int u, input bit b);
        pd[u] = b;
        tick(5);
        pc[u] = 1'b0;
        drv_p[u] = cyc + SYNC;
        feq[u].push_back('{cyc + SYNC, b});
        tick(10);
        pc[u] = 1'b1;
        tick(5);
    endtask
    task automatic frame(input int u, input logic [8:0] d, input bit flip, input bit stop, input int lim);
        logic [11:0] w;
        int n;
        bit p;
        p = ($countones(d) % 2 == 0) ? (pmode(u) == 1) : (pmode(u) == 2);
        w = '0;
        for (int i = 0; i < dbits(u); i++) w[1+i] = d[i];
        n = 1 + dbits(u);
        if (pmode(u) != 0) begin
            w[n] = p ^ flip;
            n = n + 1;
        end
        w[n] = stop;
        n = n + 1;
        for (int i = 0; i < n && i < lim; i++) bitout(u, w[i]);
    endtask
    // Model state (owned by the checker process only)
    logic [8:0] mq[3][$];
    bit inf[3], popf[3];
    int nb[3], lastm[3], fi[3], pi[3], ti[3], ci[3];
    logic [8:0] md[3];
    bit rst_s = 0;
    bit en = 0;
    int npe[3], nfe[3], nte[3], nof[3];
    task automatic chk(input string nm, input int u, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, u, cyc, got, exp);
        end
    endtask
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            bit epe, efe, ete, eof, b;
            epe = 0; efe = 0; ete = 0; eof = 0;
            while (fi[u] < feq[u].size() && feq[u][fi[u]].p < cyc - 1) fi[u]++;
            if (rst_s) begin
                mq[u].delete();
                inf[u] = 0;
                if (en) chk("reset_data", u, int'(od[u]), 0);
            end else begin
                if (popf[u]) void'(mq[u].pop_front());
                if (fi[u] < feq[u].size() && feq[u][fi[u]].p == cyc - 1) begin
                    b = feq[u][fi[u]].b;
                    fi[u]++;
                    if (!inf[u]) begin
                        if (!b) begin
                            inf[u] = 1; nb[u] = 0; md[u] = '0; lastm[u] = cyc - 1;
                        end
                    end else begin
                        nb[u]++;
                        lastm[u] = cyc - 1;
                        if (nb[u] <= dbits(u)) md[u][nb[u]-1] = b;
                        else if (pmode(u) != 0 && nb[u] == dbits(u) + 1) begin
                            if ((($countones(md[u]) + int'(b)) % 2) != ((pmode(u) == 1) ? 1 : 0)) begin
                                epe = 1; inf[u] = 0;
                            end
                        end else begin
                            inf[u] = 0;
                            if (!b) efe = 1;
                            else if (mq[u].size() == DEP) eof = 1;
                            else mq[u].push_back(md[u]);
                        end
                    end
                end
                if (inf[u] && cyc == lastm[u] + TO) begin
                    ete = 1; inf[u] = 0;
                end
            end
            if (rst_s) en = 1;
            if (en) begin
                chk("valid", u, int'(ov[u]), int'(mq[u].size() > 0));
                chk("count", u, int'(oc[u]), mq[u].size());
                if (mq[u].size() > 0) chk("data", u, int'(od[u]), int'(mq[u][0]));
                chk("parity_err", u, int'(pe[u]), int'(epe));
                chk("frame_err", u, int'(fr[u]), int'(efe));
                chk("timeout_err", u, int'(te[u]), int'(ete));
                chk("overflow", u, int'(of[u]), int'(eof));
                npe[u] += int'(pe[u]); nfe[u] += int'(fr[u]); nte[u] += int'(te[u]); nof[u] += int'(of[u]);
                if (!reset && ov[u] && rdy[u]) begin
                    if (pi[u] < litpop[u].size()) begin
                        chk("pop_literal", u, int'(od[u]), int'(litpop[u][pi[u]]));
                        pi[u]++;
                    end else chk("unexpected_pop", u, int'(od[u]), -1);
                end
                if (te[u]) begin
                    if (ti[u] < littmo[u].size()) begin
                        chk("timeout_cycle", u, cyc, littmo[u][ti[u]]);
                        ti[u]++;
                    end else chk("unexpected_timeout", u, cyc, -1);
                end
                if (ci[u] < litcnt[u].size() && litcnt[u][ci[u]].c == cyc) begin
                    chk("count_literal", u, int'(oc[u]), litcnt[u][ci[u]].v);
                    ci[u]++;
                end
            end
            popf[u] = !reset && rdy[u] && mq[u].size() > 0;
        end
        rst_s = reset;
        if (done) begin
            for (int u = 0; u < 3; u++) begin
                chk("pops_left", u, litpop[u].size() - pi[u], 0);
                chk("timeouts_left", u, littmo[u].size() - ti[u], 0);
                chk("counts_left", u, litcnt[u].size() - ci[u], 0);
                chk("total_parity_err", u, npe[u], tot_pe[u]);
                chk("total_frame_err", u, nfe[u], tot_fe[u]);
                chk("total_timeout_err", u, nte[u], tot_te[u]);
                chk("total_overflow", u, nof[u], tot_of[u]);
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end
    initial begin
        for (int u = 0; u < 3; u++) begin
            pc[u] = 1'b1; pd[u] = 1'b1; rdy[u] = 1'b1;
            tot_pe[u] = 0; tot_fe[u] = 0; tot_te[u] = 0; tot_of[u] = 0;
        end
        tick(3);
        reset = 1'b0;
        tick(5);
        // 8 bits, odd parity: 0x55 has four ones, parity bit 1
        litpop[0].push_back(9'h055);
        frame(0, 9'h055, 0, 1, 99);
        tick(20);
        frame(0, 9'h055, 1, 1, 99);
        tick(20);
        // 0xA3 has four ones, parity bit 1
        litpop[0].push_back(9'h0A3);
        frame(0, 9'h0A3, 0, 1, 99);
        tick(20);
        // 0x1C with correct parity 0 and a bad stop bit
        frame(0, 9'h01C, 0, 0, 99);
        tick(20);
        // device clock stops after D3
        frame(0, 9'h077, 0, 1, 5);
        littmo[0].push_back(drv_p[0] + TO);
        tick(150);
        litpop[0].push_back(9'h029);
        frame(0, 9'h029, 0, 1, 99);
        tick(20);
        rdy[0] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            frame(0, 9'(i), 0, 1, 99);
            tick(20);
        end
        litcnt[0].push_back('{cyc + 3, 4});
        tick(10);
        for (int i = 1; i <= 4; i++) litpop[0].push_back(9'(i));
        rdy[0] = 1'b1;
        tick(20);
        tot_pe[0] = 1; tot_fe[0] = 1; tot_te[0] = 1; tot_of[0] = 1;
        // 7 bits, no parity
        litpop[1].push_back(9'h03F);
        frame(1, 9'h03F, 0, 1, 99);
        tick(20);
        frame(1, 9'h03F, 0, 1, 4);
        tick(5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(30);
        litpop[1].push_back(9'h03F);
        frame(1, 9'h03F, 0, 1, 99);
        tick(20);
        // 9 bits, even parity: 0x1A5 has five ones, parity bit 1
        litpop[2].push_back(9'h1A5);
        frame(2, 9'h1A5, 0, 1, 99);
        tick(20);
        frame(2, 9'h0F0, 1, 1, 99);
        tick(20);
        litpop[2].push_back(9'h00B);
        frame(2, 9'h00B, 0, 1, 99);
        tick(20);
        tot_pe[2] = 1;
        done = 1;
    end
endmodule
